// File: rtl/entrada_captura.sv
// entrada_captura: debounced key capture of slide switches for the CPU input instruction,
// stalling the CPU until the user confirms.
module entrada_captura #(
  parameter int SW_WIDTH        = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SIGN_EXT        = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SW_WIDTH-1:0] Switches,
  input  logic                Botao,
  input  logic                EnableIn,
  output logic [31:0]         ValorEntrada,
  output logic                Pausa,
  output logic                Valido,
  output logic                LedEspera
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, WAIT_PRESS, WAIT_DROP} state_t;
  state_t                               state;
  logic [SYNC_STAGES-1:0]               key_sr;
  logic [SYNC_STAGES-1:0][SW_WIDTH-1:0] sw_sr;
  logic                                 key_s;
  logic                                 deb;
  logic [CW-1:0]                        cnt;
  logic [SW_WIDTH-1:0]                  sw_s;
  logic                                 toggle;
  logic                                 press_evt;
  logic [31:0]                          ext;
  assign key_s     = key_sr[SYNC_STAGES-1];
  assign sw_s      = sw_sr[SYNC_STAGES-1];
  assign toggle    = (key_s != deb) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign press_evt = toggle && !key_s;
  assign LedEspera = Pausa;
  if (SW_WIDTH >= 32) begin : g_wide
    assign ext = sw_s[31:0];
  end else begin : g_ext
    assign ext = {{(32-SW_WIDTH){(SIGN_EXT != 0) && sw_s[SW_WIDTH-1]}}, sw_s};
  end
  // key idles high (released); the counter only runs while the synced key disagrees
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_sr <= '1;
      sw_sr  <= '0;
      deb    <= 1'b1;
      cnt    <= '0;
    end else begin
      key_sr <= {key_sr[SYNC_STAGES-2:0], Botao};
      sw_sr  <= {sw_sr[SYNC_STAGES-2:0], Switches};
      deb    <= toggle ? key_s : deb;
      cnt    <= (key_s == deb || toggle) ? '0 : cnt + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      ValorEntrada <= '0;
      Pausa        <= 1'b0;
      Valido       <= 1'b0;
    end else begin
      Valido <= 1'b0;
      case (state)
        IDLE: if (EnableIn) begin
          state <= WAIT_PRESS;
          Pausa <= 1'b1;
        end
        WAIT_PRESS: if (press_evt) begin
          ValorEntrada <= ext;
          Valido       <= 1'b1;
          Pausa        <= 1'b0;
          state        <= WAIT_DROP;
        end else if (!EnableIn) begin
          Pausa <= 1'b0;
          state <= IDLE;
        end
        WAIT_DROP: if (!EnableIn) state <= IDLE;
        default: begin
          state <= IDLE;
          Pausa <= 1'b0;
        end
      endcase
    end
  end
endmodule
